spi_memory_slave: RTL and testbench

SPI memory-device responder (CPOL=0, CPHA=0) that lets the FPGA answer a flash-style master: it decodes opcode, address and dummy phases from the serial bus and turns them into parallel read-request and write-strobe handshakes toward an internal memory or register backend. It is oversampled by `main_clock`: SCK, CS and MOSI pass through synchronizers and are edge-detected, so SCK must be much slower than `main_clock`. It sits between the external SPI pins and the frame/config memory backend.

---
 rtl/spi_memory_slave_if.sv | 34 +++
 rtl/spi_memory_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_spi_memory_slave.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_memory_slave_if.sv
// SPI pin bundle plus the parallel memory-backend handshake of spi_memory_slave.
interface spi_memory_slave_if #(
    parameter int unsigned ADDR_BYTES = 3
);
    localparam int unsigned ADDR_W = 8 * ADDR_BYTES;

    logic              sck;
    logic              cs;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic              cmd_valid;
    logic [7:0]        cmd_opcode;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic [2:0]        state_out;

    modport slave (
        input  sck, cs, mosi, rd_data,
        output miso, miso_oe, cmd_valid, cmd_opcode, rd_req, rd_addr,
               wr_valid, wr_addr, wr_data, busy, state_out
    );

    modport master (
        output sck, cs, mosi, rd_data,
        input  miso, miso_oe, cmd_valid, cmd_opcode, rd_req, rd_addr,
               wr_valid, wr_addr, wr_data, busy, state_out
    );
endinterface

// File: rtl/spi_memory_slave.sv
// Oversampled SPI mode-0 flash-style responder: decodes READ / FAST_READ / PAGE_PROGRAM
// into parallel read-request and write-strobe handshakes.
module spi_memory_slave #(
    parameter int unsigned ADDR_BYTES = 3,
    parameter int unsigned FAST_DUMMY = 8
) (
    input  logic                  main_clock,
    input  logic                  reset,
    spi_memory_slave_if.slave     bus
);
    localparam int unsigned ADDR_W = 8 * ADDR_BYTES;
    localparam int unsigned CNT_W  = 9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_OPCODE = 3'd1,
        S_ADDR   = 3'd2,
        S_DUMMY  = 3'd3,
        S_READ   = 3'd4,
        S_WRITE  = 3'd5,
        S_IGNORE = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic              sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_dly_q, sck_dly_d;
    logic              cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d;
    logic              mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
    logic              armed_q, armed_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]        tx_cnt_q, tx_cnt_d;
    logic [ADDR_W-1:0] shift_q, shift_d;
    logic [6:0]        tx_shift_q, tx_shift_d;
    logic              miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmd_opcode_q, cmd_opcode_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;

    logic              sck_rise, sck_fall;
    logic [ADDR_W-1:0] shifted;

    assign sck_rise = sck_s2_q & ~sck_dly_q;
    assign sck_fall = ~sck_s2_q & sck_dly_q;
    assign shifted  = {shift_q[ADDR_W-2:0], mosi_s2_q};

    always_comb begin
        state_d      = state_q;
        sck_s1_d     = bus.sck;
        sck_s2_d     = sck_s1_q;
        sck_dly_d    = sck_s2_q;
        cs_s1_d      = bus.cs;
        cs_s2_d      = cs_s1_q;
        mosi_s1_d    = bus.mosi;
        mosi_s2_d    = mosi_s1_q;
        armed_d      = armed_q | cs_s2_q;
        bit_cnt_d    = bit_cnt_q;
        tx_cnt_d     = tx_cnt_q;
        shift_d      = shift_q;
        tx_shift_d   = tx_shift_q;
        miso_d       = miso_q;
        cmd_valid_d  = 1'b0;
        cmd_opcode_d = cmd_opcode_q;
        rd_req_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_valid_q ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
        wr_data_d    = wr_data_q;

        // CS release overrides any byte that completes in the same cycle
        if (cs_s2_q) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            tx_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // armed only after CS has been seen high since reset
                    if (armed_q) begin
                        state_d   = S_OPCODE;
                        bit_cnt_d = '0;
                    end
                end
                S_OPCODE: if (sck_rise) begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_d    = '0;
                        cmd_opcode_d = shifted[7:0];
                        case (shifted[7:0])
                            8'h03, 8'h0B, 8'h02: state_d = S_ADDR;
                            default: begin
                                state_d     = S_IGNORE;
                                cmd_valid_d = 1'b1;
                            end
                        endcase
                    end
                end
                S_ADDR: if (sck_rise) begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                        bit_cnt_d   = '0;
                        tx_cnt_d    = '0;
                        cmd_valid_d = 1'b1;
                        case (cmd_opcode_q)
                            8'h03: begin
                                rd_addr_d = shifted;
                                rd_req_d  = 1'b1;
                                state_d   = S_READ;
                            end
                            8'h0B: begin
                                rd_addr_d = shifted;
                                state_d   = S_DUMMY;
                            end
                            default: begin
                                wr_addr_d = shifted;
                                state_d   = S_WRITE;
                            end
                        endcase
                    end
                end
                S_DUMMY: if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(FAST_DUMMY - 1)) begin
                        bit_cnt_d = '0;
                        rd_req_d  = 1'b1;
                        state_d   = S_READ;
                    end
                end
                S_READ: begin
                    // first fall of each byte loads the backend byte; later falls shift
                    if (sck_fall) begin
                        tx_cnt_d = tx_cnt_q + 3'd1;
                        if (tx_cnt_q == 3'd0) begin
                            miso_d     = bus.rd_data[7];
                            tx_shift_d = bus.rd_data[6:0];
                        end else begin
                            miso_d     = tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[5:0], 1'b0};
                        end
                    end
                    // prefetch the next byte on the last sampled bit of this one
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            bit_cnt_d = '0;
                            rd_addr_d = rd_addr_q + ADDR_W'(1);
                            rd_req_d  = 1'b1;
                        end
                    end
                end
                S_WRITE: if (sck_rise) begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_d  = '0;
                        wr_valid_d = 1'b1;
                        wr_data_d  = shifted[7:0];
                    end
                end
                S_IGNORE: miso_d = 1'b0;
                default:  state_d = S_IDLE;
            endcase
        end

        if (state_d != S_READ) begin
            miso_d = 1'b0;
        end
        miso_oe_d = (state_d == S_READ);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge main_clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sck_s1_q     <= 1'b0;
            sck_s2_q     <= 1'b0;
            sck_dly_q    <= 1'b0;
            cs_s1_q      <= 1'b0;
            cs_s2_q      <= 1'b0;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            armed_q      <= 1'b0;
            bit_cnt_q    <= '0;
            tx_cnt_q     <= '0;
            shift_q      <= '0;
            tx_shift_q   <= '0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_opcode_q <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sck_s1_q     <= sck_s1_d;
            sck_s2_q     <= sck_s2_d;
            sck_dly_q    <= sck_dly_d;
            cs_s1_q      <= cs_s1_d;
            cs_s2_q      <= cs_s2_d;
            mosi_s1_q    <= mosi_s1_d;
            mosi_s2_q    <= mosi_s2_d;
            armed_q      <= armed_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            shift_q      <= shift_d;
            tx_shift_q   <= tx_shift_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_opcode_q <= cmd_opcode_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.miso       = miso_q;
    assign bus.miso_oe    = miso_oe_q;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_opcode = cmd_opcode_q;
    assign bus.rd_req     = rd_req_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = busy_q;
    assign bus.state_out  = state_q;
endmodule

// File: tb/tb_spi_memory_slave.sv
// Directed bench for spi_memory_slave: table of SPI transactions plus reset/abort sequences.
module tb_spi_memory_slave;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    spi_memory_slave_if #(.ADDR_BYTES(3)) bus ();

    spi_memory_slave #(.ADDR_BYTES(3), .FAST_DUMMY(8)) dut (
        .main_clock (clk),
        .reset      (rst),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       op;
        logic [23:0]      addr;
        int               nbytes;
        logic [2:0][7:0]  tx;
        logic [2:0][7:0]  exp_rx;
        logic [2:0]       exp_state;
        int               exp_rd_n;
        logic [23:0]      exp_rd_a0, exp_rd_a1, exp_rd_a2;
        int               exp_wr_n;
        logic [23:0]      exp_wr_a0;
        logic [7:0]       exp_wr_d0;
        logic [23:0]      exp_wr_a1;
        logic [7:0]       exp_wr_d1;
    } vec_t;

    // Bus monitor and backend: the backend returns rd_addr[7:0]
    logic [23:0] rd_log[$];
    logic [23:0] wr_a_log[$];
    logic [7:0]  wr_d_log[$];
    logic [7:0]  cmd_log[$];
    int          oe_in_dummy = 0;

    always @(negedge clk) begin
        if (rst) begin
            bus.rd_data = 8'h00;
        end else begin
            if (bus.rd_req) begin
                rd_log.push_back(bus.rd_addr);
                bus.rd_data = bus.rd_addr[7:0];
            end
            if (bus.wr_valid) begin
                wr_a_log.push_back(bus.wr_addr);
                wr_d_log.push_back(bus.wr_data);
            end
            if (bus.cmd_valid) cmd_log.push_back(bus.cmd_opcode);
            if (bus.state_out == 3'd3 && bus.miso_oe) oe_in_dummy++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], bus.miso};
            bus.sck = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sck = 1'b0;
        end
    endtask

    task automatic release_cs();
        repeat (HALF) @(negedge clk);
        bus.cs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " state"},   32'(bus.state_out), 32'd0);
        chk({tag, " busy"},    32'(bus.busy),      32'd0);
        chk({tag, " miso_oe"}, 32'(bus.miso_oe),   32'd0);
        chk({tag, " miso"},    32'(bus.miso),      32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int rd0, wr0, cmd0;
        logic [7:0] rx;
        rd0  = rd_log.size();
        wr0  = wr_a_log.size();
        cmd0 = cmd_log.size();
        bus.cs = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(v.op, 8, rx);
        if (v.op == 8'h03 || v.op == 8'h0B || v.op == 8'h02) begin
            for (int k = 0; k < 3; k++) send_bits(v.addr[8*(2-k) +: 8], 8, rx);
        end
        if (v.op == 8'h0B) send_bits(8'h00, 8, rx);
        for (int k = 0; k < v.nbytes; k++) begin
            send_bits(v.tx[k], 8, rx);
            chk($sformatf("%s rx%0d", tag, k), 32'(rx), 32'(v.exp_rx[k]));
        end
        repeat (HALF) @(negedge clk);
        chk({tag, " state_mid"}, 32'(bus.state_out), 32'(v.exp_state));
        release_cs();
        chk({tag, " rd_cnt"}, 32'(rd_log.size() - rd0), 32'(v.exp_rd_n));
        if (v.exp_rd_n > 0 && rd_log.size() > rd0)     chk({tag, " rd_a0"}, 32'(rd_log[rd0]),   32'(v.exp_rd_a0));
        if (v.exp_rd_n > 1 && rd_log.size() > rd0 + 1) chk({tag, " rd_a1"}, 32'(rd_log[rd0+1]), 32'(v.exp_rd_a1));
        if (v.exp_rd_n > 2 && rd_log.size() > rd0 + 2) chk({tag, " rd_a2"}, 32'(rd_log[rd0+2]), 32'(v.exp_rd_a2));
        chk({tag, " wr_cnt"}, 32'(wr_a_log.size() - wr0), 32'(v.exp_wr_n));
        if (v.exp_wr_n > 0 && wr_a_log.size() > wr0) begin
            chk({tag, " wr_a0"}, 32'(wr_a_log[wr0]), 32'(v.exp_wr_a0));
            chk({tag, " wr_d0"}, 32'(wr_d_log[wr0]), 32'(v.exp_wr_d0));
        end
        if (v.exp_wr_n > 1 && wr_a_log.size() > wr0 + 1) begin
            chk({tag, " wr_a1"}, 32'(wr_a_log[wr0+1]), 32'(v.exp_wr_a1));
            chk({tag, " wr_d1"}, 32'(wr_d_log[wr0+1]), 32'(v.exp_wr_d1));
        end
        chk({tag, " cmd_cnt"}, 32'(cmd_log.size() - cmd0), 32'd1);
        if (cmd_log.size() > cmd0) chk({tag, " cmd_op"}, 32'(cmd_log[cmd0]), 32'(v.op));
        check_idle(tag);
    endtask

    initial begin
        #400us;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        vec_t rec;
        logic [7:0] rx;
        int rd0, wr0, cmd0;

        // Each read byte ends with a prefetch, so N bytes give N+1 requests
        vecs[0] = '{8'h03, 24'h000100, 3, 24'h000000, 24'h020100, 3'd4, 4,
                    24'h000100, 24'h000101, 24'h000102, 0, 24'h0, 8'h0, 24'h0, 8'h0};
        vecs[1] = '{8'h0B, 24'h000010, 2, 24'h000000, 24'h001110, 3'd4, 3,
                    24'h000010, 24'h000011, 24'h000012, 0, 24'h0, 8'h0, 24'h0, 8'h0};
        vecs[2] = '{8'h02, 24'h000020, 2, 24'h005AA5, 24'h000000, 3'd5, 0,
                    24'h0, 24'h0, 24'h0, 2, 24'h000020, 8'hA5, 24'h000021, 8'h5A};
        vecs[3] = '{8'h9F, 24'h000000, 2, 24'h00C3A5, 24'h000000, 3'd6, 0,
                    24'h0, 24'h0, 24'h0, 0, 24'h0, 8'h0, 24'h0, 8'h0};
        vecs[4] = '{8'h03, 24'hFFFFFF, 2, 24'h000000, 24'h0000FF, 3'd4, 3,
                    24'hFFFFFF, 24'h000000, 24'h000001, 0, 24'h0, 8'h0, 24'h0, 8'h0};

        rst = 1'b1;
        bus.sck = 1'b0;
        bus.cs = 1'b1;
        bus.mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        chk("reset cmd_opcode", 32'(bus.cmd_opcode), 32'd0);
        chk("reset rd_addr",    32'(bus.rd_addr),    32'd0);
        chk("reset wr_addr",    32'(bus.wr_addr),    32'd0);
        chk("reset wr_data",    32'(bus.wr_data),    32'd0);
        chk("reset strobes",    32'({bus.cmd_valid, bus.rd_req, bus.wr_valid}), 32'd0);
        repeat (8) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        chk("fast_read oe_in_dummy", 32'(oe_in_dummy), 32'd0);

        // PAGE_PROGRAM aborted 4 bits into the second byte
        wr0 = wr_a_log.size();
        bus.cs = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(8'h02, 8, rx);
        send_bits(8'h00, 8, rx);
        send_bits(8'h00, 8, rx);
        send_bits(8'h40, 8, rx);
        send_bits(8'h11, 8, rx);
        send_bits(8'hF0, 4, rx);
        release_cs();
        chk("abort wr_cnt", 32'(wr_a_log.size() - wr0), 32'd1);
        if (wr_a_log.size() > wr0) begin
            chk("abort wr_a0", 32'(wr_a_log[wr0]), 32'h40);
            chk("abort wr_d0", 32'(wr_d_log[wr0]), 32'h11);
        end
        check_idle("abort");

        // Reset in the ADDR phase, then bits with CS still low must be ignored
        rd0 = rd_log.size();
        wr0 = wr_a_log.size();
        cmd0 = cmd_log.size();
        bus.cs = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(8'h03, 8, rx);
        send_bits(8'h12, 8, rx);
        chk("pre_reset state", 32'(bus.state_out), 32'd2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("midreset");
        chk("midreset cmd_opcode", 32'(bus.cmd_opcode), 32'd0);
        chk("midreset rd_addr",    32'(bus.rd_addr),    32'd0);
        chk("midreset wr_addr",    32'(bus.wr_addr),    32'd0);
        send_bits(8'h34, 8, rx);
        send_bits(8'h56, 8, rx);
        send_bits(8'h03, 8, rx);
        chk("midreset held state", 32'(bus.state_out), 32'd0);
        release_cs();
        chk("midreset rd_cnt",  32'(rd_log.size() - rd0),    32'd0);
        chk("midreset wr_cnt",  32'(wr_a_log.size() - wr0),  32'd0);
        chk("midreset cmd_cnt", 32'(cmd_log.size() - cmd0),  32'd0);

        rec = '{8'h03, 24'h000005, 1, 24'h000000, 24'h000005, 3'd4, 2,
                24'h000005, 24'h000006, 24'h0, 0, 24'h0, 8'h0, 24'h0, 8'h0};
        run_vec(rec, "recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
